// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD de-interleaver.
package simd_pkg;
    localparam int SIMD_WIDTH = 256;
    localparam int HALF_W     = SIMD_WIDTH / 2;

    localparam logic [2:0] MODE_8   = 3'd0;
    localparam logic [2:0] MODE_16  = 3'd1;
    localparam logic [2:0] MODE_32  = 3'd2;
    localparam logic [2:0] MODE_64  = 3'd3;
    localparam logic [2:0] MODE_128 = 3'd4;
    localparam logic [2:0] MODE_256 = 3'd5;

    typedef enum logic [1:0] {IDLE, HALF, FULL} state_t;
endpackage

// File: rtl/simd_lane_split.sv
// Combinational split of one interleaved beat into its A and B half-vectors.
// Modes 5..7 have no pairing, so both halves read as zero there.
module simd_lane_split
    import simd_pkg::*;
(
    input  logic [SIMD_WIDTH-1:0] in_data,
    input  logic [2:0]            mode,
    output logic [HALF_W-1:0]     a_half,
    output logic [HALF_W-1:0]     b_half
);
    logic [4:0][HALF_W-1:0] a_m;
    logic [4:0][HALF_W-1:0] b_m;

    // Word j of width 2W carries {A_j, B_j}; element j lands at [j*W +: W].
    for (genvar m = 0; m < 5; m++) begin : g_mode
        localparam int W  = 8 << m;
        localparam int NH = (SIMD_WIDTH / W) / 2;
        for (genvar j = 0; j < NH; j++) begin : g_el
            assign a_m[m][j*W +: W] = in_data[(j+1)*2*W-1 -: W];
            assign b_m[m][j*W +: W] = in_data[j*2*W +: W];
        end
    end

    always_comb begin
        a_half = '0;
        b_half = '0;
        case (mode)
            MODE_8:   begin a_half = a_m[0]; b_half = b_m[0]; end
            MODE_16:  begin a_half = a_m[1]; b_half = b_m[1]; end
            MODE_32:  begin a_half = a_m[2]; b_half = b_m[2]; end
            MODE_64:  begin a_half = a_m[3]; b_half = b_m[3]; end
            MODE_128: begin a_half = a_m[4]; b_half = b_m[4]; end
            default:  ;
        endcase
    end
endmodule

// File: rtl/simd_deinterleaver.sv
// Two-beat de-interleaver: low/high beats of {A,B} pairs rebuilt into A and B vectors.
// Define SIMD_DEINTERLEAVER_ERR_EN to enable protocol checking and the err pulse.
module simd_deinterleaver #(
    parameter int SIMD_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] in_data,
    input  logic                  in_hi,
    input  logic [2:0]            data_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] out_a,
    output logic [SIMD_WIDTH-1:0] out_b,
    output logic                  err
);
    import simd_pkg::*;

`ifdef SIMD_DEINTERLEAVER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int HW = SIMD_WIDTH / 2;

    state_t                state_q, state_d;
    logic [SIMD_WIDTH-1:0] a_q, b_q;
    logic [2:0]            mode_q, split_mode;
    logic [HW-1:0]         a_half, b_half;
    logic                  rdy_en_q, err_q, err_d;
    logic                  accept, mode_ok, ld_lo, ld_hi, ld_full;

    assign accept  = in_valid && in_ready;
    // Without checking, the latched mode alone decides how the high beat splits.
    assign mode_ok = !ERR_EN || (data_mode == mode_q);
    assign split_mode = (state_q == HALF && in_hi) ? mode_q : data_mode;

    simd_lane_split u_split (
        .in_data (in_data),
        .mode    (split_mode),
        .a_half  (a_half),
        .b_half  (b_half)
    );

    always_comb begin
        state_d = state_q;
        ld_lo   = 1'b0;
        ld_hi   = 1'b0;
        ld_full = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (data_mode >= MODE_256) begin
                    ld_full = 1'b1;
                    state_d = FULL;
                end else if (!in_hi) begin
                    ld_lo   = 1'b1;
                    state_d = HALF;
                end else begin
                    err_d   = 1'b1;
                end
            end
            HALF: if (accept) begin
                if (!in_hi) begin
                    ld_lo   = 1'b1;
                    err_d   = 1'b1;
                end else if (mode_ok) begin
                    ld_hi   = 1'b1;
                    state_d = FULL;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FULL: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_8;
            rdy_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            err_q    <= ERR_EN && err_d;
            if (ld_full) begin
                a_q <= in_data;
                b_q <= '0;
            end
            if (ld_lo) begin
                a_q[HW-1:0] <= a_half;
                b_q[HW-1:0] <= b_half;
                mode_q      <= data_mode;
            end
            if (ld_hi) begin
                a_q[SIMD_WIDTH-1:HW] <= a_half;
                b_q[SIMD_WIDTH-1:HW] <= b_half;
            end
        end
    end

    // in_ready stays low through reset and rises on the first edge after it.
    assign in_ready  = rdy_en_q && (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign err       = ERR_EN ? err_q : 1'b0;
endmodule

// File: tb/tb_simd_deinterleaver.sv
// Directed self-checking bench for simd_deinterleaver (both ERR_EN builds).
module tb_simd_deinterleaver;
`ifdef SIMD_DEINTERLEAVER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_hi, out_valid, out_ready, err;
    logic [255:0] in_data, out_a, out_b;
    logic [2:0]   data_mode;
    int           n_vec = 0;
    int           n_bad = 0;

    simd_deinterleaver #(.SIMD_WIDTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_hi     (in_hi),
        .data_mode (data_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Present one beat for exactly one cycle; returns at the negedge after acceptance.
    task automatic beat(input logic [255:0] d, input logic hi, input logic [2:0] m);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_hi     = hi;
        data_mode = m;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [255:0] lo, hi, ea, eb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_hi = 1'b0;
        data_mode = 3'd0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        rst = 1'b0;
        #1 chk("rdy_before_edge", in_ready, 0);
        @(negedge clk);
        chk("rdy_after_edge", in_ready, 1);

        // mode 0: A0=02 B0=01, A16=04 B16=03
        beat(256'h0201, 1'b0, 3'd0);
        chk("m0_half_valid", out_valid, 0);
        beat(256'h0403, 1'b1, 3'd0);
        chk("m0_valid", out_valid, 1);
        ea = '0; ea[7:0] = 8'h02; ea[135:128] = 8'h04;
        eb = '0; eb[7:0] = 8'h01; eb[135:128] = 8'h03;
        chk("m0_a", out_a, ea);
        chk("m0_b", out_b, eb);
        drain();

        // mode 1: words {3333,4444},{1111,2222} then {7777,8888},{5555,6666}
        beat(256'h1111_2222_3333_4444, 1'b0, 3'd1);
        beat(256'h5555_6666_7777_8888, 1'b1, 3'd1);
        ea = '0; ea[31:0] = 32'h1111_3333; ea[159:128] = 32'h5555_7777;
        eb = '0; eb[31:0] = 32'h2222_4444; eb[159:128] = 32'h6666_8888;
        chk("m1_a", out_a, ea);
        chk("m1_b", out_b, eb);
        drain();

        // mode 4 with backpressure
        beat({{16{8'h11}}, {16{8'h22}}}, 1'b0, 3'd4);
        beat({{16{8'h33}}, {16{8'h44}}}, 1'b1, 3'd4);
        ea = {{16{8'h33}}, {16{8'h11}}};
        eb = {{16{8'h44}}, {16{8'h22}}};
        for (int c = 0; c < 5; c++) begin
            chk("bp_a", out_a, ea);
            chk("bp_b", out_b, eb);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            @(negedge clk);
        end
        drain();
        chk("bp_drained_valid", out_valid, 0);
        chk("bp_drained_ready", in_ready, 1);

        // mode 5: single beat, in_hi ignored
        lo = {8{32'hDEAD_BEEF}};
        beat(lo, 1'b1, 3'd5);
        chk("m5_valid", out_valid, 1);
        chk("m5_a", out_a, lo);
        chk("m5_b", out_b, 0);
        drain();

        // stray high beat in IDLE
        beat(256'h9999, 1'b1, 3'd0);
        chk("stray_err", err, ERR_EN);
        chk("stray_valid", out_valid, 0);
        @(negedge clk);
        chk("stray_err_clear", err, 0);
        chk("stray_idle", in_ready, 1);

        // mode mismatch: low at mode 2, high at mode 3
        beat(256'hAAAA_AAAA_BBBB_BBBB, 1'b0, 3'd2);
        beat(256'hCCCC_CCCC_DDDD_DDDD, 1'b1, 3'd3);
        chk("mm_err", err, ERR_EN);
        chk("mm_valid", out_valid, !ERR_EN);
        if (!ERR_EN) begin
            ea = '0; ea[31:0] = 32'hAAAA_AAAA; ea[159:128] = 32'hCCCC_CCCC;
            eb = '0; eb[31:0] = 32'hBBBB_BBBB; eb[159:128] = 32'hDDDD_DDDD;
            chk("mm_a", out_a, ea);
            chk("mm_b", out_b, eb);
            drain();
        end else begin
            @(negedge clk);
            chk("mm_err_clear", err, 0);
            chk("mm_idle_ready", in_ready, 1);
        end

        // repeat low beat overwrites the low half
        beat({{16{8'h11}}, {16{8'h22}}}, 1'b0, 3'd4);
        beat({{16{8'h55}}, {16{8'h66}}}, 1'b0, 3'd4);
        chk("rl_err", err, ERR_EN);
        chk("rl_valid", out_valid, 0);
        beat({{16{8'h33}}, {16{8'h44}}}, 1'b1, 3'd4);
        chk("rl_a", out_a, {{16{8'h33}}, {16{8'h55}}});
        chk("rl_b", out_b, {{16{8'h44}}, {16{8'h66}}});
        drain();

        // async reset mid-cycle while in HALF (during an err pulse when enabled)
        beat(256'h0201, 1'b0, 3'd0);
        beat(256'h0605, 1'b0, 3'd0);
        chk("ar_err_pre", err, ERR_EN);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_err", err, 0);
        chk("ar_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_ready_back", in_ready, 1);
        beat(256'h0807, 1'b0, 3'd0);
        beat(256'h0A09, 1'b1, 3'd0);
        chk("ar_pair_valid", out_valid, 1);
        ea = '0; ea[7:0] = 8'h08; ea[135:128] = 8'h0A;
        eb = '0; eb[7:0] = 8'h07; eb[135:128] = 8'h09;
        chk("ar_pair_a", out_a, ea);
        chk("ar_pair_b", out_b, eb);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/simd_deinterleaver.md
SIMD_DEINTERLEAVER -- requirements
Module: simd_deinterleaver

Interface
REQ-001 SHALL have parameter SIMD_WIDTH, default 256, vector width in bits; only 256 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, input beat present.
REQ-005 SHALL have port in_ready, output, 1, block accepts an input beat this cycle.
REQ-006 SHALL have port in_data, input, 256, interleaved vector of {A_k,B_k} pairs.
REQ-007 SHALL have port in_hi, input, 1, beat tag: 0 = low-half beat, 1 = high-half beat.
REQ-008 SHALL have port data_mode, input, 3, element width: 0=8b, 1=16b, 2=32b, 3=64b, 4=128b, 5..7=256b.
REQ-009 SHALL have port out_valid, output, 1, reconstructed pair available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the output.
REQ-011 SHALL have port out_a, output, 256, reconstructed A vector.
REQ-012 SHALL have port out_b, output, 256, reconstructed B vector.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a protocol violation.

Function
REQ-014 Element width is W, N = 256/W; beat word j (bits [(j+1)*2W-1 -: 2W]) holds {A_k, B_k}, with A_k in the upper half; k = j for a low beat and k = j+N/2 for a high beat, j = 0..N/2-1.
REQ-015 SHALL implement states IDLE, HALF and FULL; an input beat is accepted when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE and HALF and 0 in FULL.
REQ-017 In IDLE, an accepted low beat with data_mode 0..4 SHALL store elements 0..N/2-1 of A and B, latch data_mode, and move to HALF.
REQ-018 In IDLE, an accepted beat with data_mode 5..7 SHALL load out_a = in_data and out_b = 0, ignore in_hi, and move to FULL.
REQ-019 In HALF, an accepted high beat with data_mode equal to the latched mode SHALL store elements N/2..N-1 and move to FULL.
REQ-020 out_valid SHALL be 1 exactly in FULL; latency is one cycle from acceptance of the completing beat to out_valid.
REQ-021 out_a and out_b SHALL be held stable while out_valid && !out_ready.
REQ-022 In FULL, out_ready = 1 SHALL return the block to IDLE on the next edge; there is no bubble-free back-to-back operation.
REQ-023 In IDLE, an accepted high beat with data_mode 0..4 SHALL be discarded and pulse err; the state stays IDLE.
REQ-024 In HALF, an accepted low beat SHALL overwrite the stored low half, relatch data_mode, pulse err, and stay in HALF.
REQ-025 In HALF, an accepted high beat whose data_mode differs from the latched mode SHALL be discarded, pulse err, and return to IDLE.
REQ-026 err SHALL assert in the cycle after the offending acceptance and last exactly one cycle.

Reset
REQ-027 rst SHALL force IDLE immediately, regardless of clk.
REQ-028 During reset, out_valid = 0, err = 0, out_a = 0, out_b = 0, the latched mode = 0, and in_ready = 0.
REQ-029 in_ready SHALL become 1 on the first clk edge after rst deasserts.
REQ-030 A reset in HALF or FULL SHALL drop the partial or pending result with no err.

Configuration
REQ-031 With macro SIMD_DEINTERLEAVER_ERR_EN defined, REQ-023..REQ-026 SHALL apply as written.
REQ-032 With SIMD_DEINTERLEAVER_ERR_EN undefined, err SHALL be tied to 0.
REQ-033 With SIMD_DEINTERLEAVER_ERR_EN undefined, stray high beats in IDLE SHALL be silently dropped, a repeat low beat in HALF SHALL silently overwrite, and the mode check SHALL be omitted, so the latched mode governs the high beat.

Structure
REQ-034 Package simd_pkg SHALL hold SIMD_WIDTH, the data_mode encodings MODE_8..MODE_256, and the state enum.
REQ-035 Sub-module simd_lane_split SHALL be combinational and map (in_data, mode) to a 128-bit A half and a 128-bit B half.
REQ-036 simd_deinterleaver SHALL own the state machine, the storage registers and the handshake.

Verification
REQ-037 Mode 0: low beat 0x..0201 (A0=02, B0=01), then high beat 0x..0403 -> one cycle later out_valid = 1, out_a byte0 = 02, out_a byte16 = 04, out_b byte0 = 01, out_b byte16 = 03.
REQ-038 Mode 4: low beat {A_lo=0x11..11, B_lo=0x22..22}, then high beat {0x33..33, 0x44..44} -> out_a = {0x33..33, 0x11..11}, out_b = {0x44..44, 0x22..22}.
REQ-039 Mode 5: a single beat of 0xDEAD..BEEF -> out_a = 0xDEAD..BEEF, out_b = 0, out_valid one cycle after acceptance.
REQ-040 out_ready held at 0 for 5 cycles -> out_a and out_b stable and in_ready = 0 throughout; out_ready = 1 -> IDLE on the next edge.
REQ-041 With ERR_EN defined: high beat in IDLE -> err one cycle and no out_valid; low beat at mode 2 then high beat at mode 3 -> err and return to IDLE.
REQ-042 Asynchronous rst asserted mid-cycle while in HALF -> out_valid and err are 0 immediately, and a following low/high pair completes correctly.
